pool_output_packer: RTL

POOL_OUTPUT_PACKER -- requirements
Module: pool_output_packer

---
 rtl/pool_output_packer_pkg.sv | 56 +++++
 rtl/pool_output_packer_slice_mux.sv | 22 ++
 rtl/pool_output_packer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_output_packer_pkg.sv
// Shared pooling configuration: word size, activation bit-planes and the
// per-unit, per-mode channel slicing tables used by pool_output_packer.
package pool_output_packer_pkg;

  localparam int POOL_SIZE_MAX = 32;
  localparam int ACT_BITS      = 3;
  localparam int PLANE_W       = $clog2(ACT_BITS);
  localparam int IDX_W         = $clog2(POOL_SIZE_MAX);
  localparam int NUM_UNITS     = 2;
  localparam int NUM_MODES     = 3;
  localparam int PARALLEL_MAX  = 8;
  localparam int CHAN_W        = 3;
  localparam int NUM_W         = 4;

  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(ACT_BITS - 1);

  localparam int PARALLEL_NUM [NUM_UNITS][NUM_MODES] = '{
    '{1, 2, 6},
    '{1, 4, 8}
  };

  localparam int PARALLEL_WIDTH [NUM_UNITS][NUM_MODES] = '{
    '{28, 10, 5},
    '{32,  8, 4}
  };

  // {low, high} bit range of each channel inside the pooled word
  localparam int PARALLEL_OUT [NUM_UNITS][NUM_MODES][PARALLEL_MAX][2] = '{
    '{
      '{'{0, 27}, '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0}, '{0, 0}},
      '{'{0, 9},  '{10, 19}, '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0}, '{0, 0}},
      '{'{0, 4},  '{6, 10},  '{12, 16}, '{17, 21}, '{22, 26}, '{27, 31}, '{0, 0}, '{0, 0}}
    },
    '{
      '{'{0, 31}, '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0}},
      '{'{0, 7},  '{8, 15},  '{16, 23}, '{24, 31}, '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0}},
      '{'{0, 3},  '{4, 7},   '{8, 11},  '{12, 15}, '{16, 19}, '{20, 23}, '{24, 27}, '{28, 31}}
    }
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_IN = 2'd1,
    ST_EMIT    = 2'd2
  } pack_state_e;

  function automatic logic [NUM_W-1:0] par_num(input int unit, input logic [1:0] m);
    return NUM_W'(PARALLEL_NUM[unit][m]);
  endfunction

  function automatic logic [IDX_W-1:0] slice_bound(input int unit, input logic [1:0] m,
                                                   input logic [CHAN_W-1:0] chan, input logic hi);
    return IDX_W'(PARALLEL_OUT[unit][m][chan][hi]);
  endfunction

endpackage

// File: rtl/pool_output_packer_slice_mux.sv
// pool_slice_mux: extracts word[high:low] and right-aligns it, upper bits zero.
module pool_slice_mux
  import pool_output_packer_pkg::*;
(
  input  logic [POOL_SIZE_MAX-1:0] word,
  input  logic [IDX_W-1:0]         low,
  input  logic [IDX_W-1:0]         high,
  output logic [POOL_SIZE_MAX-1:0] aligned
);

  logic [IDX_W:0]         width_s;
  logic [POOL_SIZE_MAX-1:0] mask_s;

  // A full-width slice sets the top width bit, which needs an all-ones mask
  always_comb begin
    width_s = {1'b0, high} - {1'b0, low} + (IDX_W + 1)'(1);
    mask_s  = width_s[IDX_W] ? {POOL_SIZE_MAX{1'b1}}
                             : ((POOL_SIZE_MAX'(1) << width_s[IDX_W-1:0]) - POOL_SIZE_MAX'(1));
    aligned = (word >> low) & mask_s;
  end

endmodule

// File: rtl/pool_output_packer.sv
// Splits each pooled bit-plane word into per-channel output words.
// Optional statistics counters are enabled with POOL_PACK_STATS_EN.
module pool_output_packer
  import pool_output_packer_pkg::*;
#(
  parameter int UNIT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [POOL_SIZE_MAX-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [POOL_SIZE_MAX-1:0] out_data,
  output logic [CHAN_W-1:0]        out_chan,
  output logic [PLANE_W-1:0]       out_plane,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err
`ifdef POOL_PACK_STATS_EN
  ,
  output logic [31:0]              stat_words,
  output logic [31:0]              stat_stalls
`endif
);

  pack_state_e              state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [CHAN_W-1:0]        p_q, p_d;
  logic [PLANE_W-1:0]       plane_q, plane_d;
  logic [POOL_SIZE_MAX-1:0] data_q, data_d;
  logic                     last_q, last_d;
  logic                     out_valid_q, out_valid_d;
  logic [POOL_SIZE_MAX-1:0] out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  logic [NUM_W-1:0]         num_s;
  logic                     final_chan_s;
  logic                     out_fire_s;
  logic                     in_ready_s;
  logic                     in_fire_s;
  logic [PLANE_W-1:0]       plane_inc_s;
  logic [PLANE_W-1:0]       word_plane_s;
  logic [POOL_SIZE_MAX-1:0] mux_word_s;
  logic [CHAN_W-1:0]        mux_p_s;
  logic [IDX_W-1:0]         low_s;
  logic [IDX_W-1:0]         high_s;
  logic [POOL_SIZE_MAX-1:0] slice_s;
  logic                     load_last_s;
  logic                     start_accept_s;

  // Handshake decode; the next input is taken during the last channel's handshake
  always_comb begin
    num_s          = par_num(UNIT, mode_q);
    final_chan_s   = ({1'b0, p_q} == (num_s - NUM_W'(1)));
    out_fire_s     = out_valid_q && out_ready;
    in_ready_s     = (state_q == ST_WAIT_IN) ||
                     ((state_q == ST_EMIT) && final_chan_s && !last_q && out_fire_s);
    in_fire_s      = in_valid && in_ready_s;
    plane_inc_s    = (plane_q == PLANE_LAST) ? '0 : plane_q + PLANE_W'(1);
    word_plane_s   = (state_q == ST_EMIT) ? plane_inc_s : plane_q;
    mux_word_s     = in_fire_s ? in_data : data_q;
    mux_p_s        = in_fire_s ? '0 : p_q + CHAN_W'(1);
    low_s          = slice_bound(UNIT, mode_q, mux_p_s, 1'b0);
    high_s         = slice_bound(UNIT, mode_q, mux_p_s, 1'b1);
    load_last_s    = ({1'b0, mux_p_s} == (num_s - NUM_W'(1))) && (in_fire_s ? in_last : last_q);
    start_accept_s = (state_q == ST_IDLE) && start && (mode != 2'd3);
  end

  pool_slice_mux u_slice (
    .word    (mux_word_s),
    .low     (low_s),
    .high    (high_s),
    .aligned (slice_s)
  );

  // Next-state and output-register computation
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    p_d         = p_q;
    plane_d     = plane_q;
    data_d      = data_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (mode == 2'd3)) begin
          err_d = 1'b1;
        end else if (start) begin
          state_d = ST_WAIT_IN;
          mode_d  = mode;
          plane_d = '0;
          p_d     = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IN: begin
        if (in_fire_s) begin
          state_d     = ST_EMIT;
          data_d      = in_data;
          last_d      = in_last;
          p_d         = '0;
          out_valid_d = 1'b1;
          out_data_d  = slice_s;
          out_last_d  = load_last_s;
          err_d       = err_q | (in_last && (word_plane_s != PLANE_LAST));
        end else begin
          state_d = ST_WAIT_IN;
        end
      end
      ST_EMIT: begin
        if (!out_fire_s) begin
          state_d = ST_EMIT;
        end else if (!final_chan_s) begin
          p_d        = mux_p_s;
          out_data_d = slice_s;
          out_last_d = load_last_s;
        end else if (in_fire_s) begin
          plane_d     = plane_inc_s;
          data_d      = in_data;
          last_d      = in_last;
          p_d         = '0;
          out_valid_d = 1'b1;
          out_data_d  = slice_s;
          out_last_d  = load_last_s;
          err_d       = err_q | (in_last && (word_plane_s != PLANE_LAST));
        end else if (last_q) begin
          plane_d     = plane_inc_s;
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          p_d         = '0;
        end else begin
          plane_d     = plane_inc_s;
          state_d     = ST_WAIT_IN;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          p_d         = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        p_d         = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'd0;
      p_q         <= '0;
      plane_q     <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      p_q         <= p_d;
      plane_q     <= plane_d;
      data_q      <= data_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = p_q;
  assign out_plane = plane_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

`ifdef POOL_PACK_STATS_EN
  logic [31:0] stat_words_q, stat_words_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  // Saturating counters, cleared when a job is accepted
  always_comb begin
    stat_words_d  = stat_words_q;
    stat_stalls_d = stat_stalls_q;
    if (start_accept_s) begin
      stat_words_d  = 32'd0;
      stat_stalls_d = 32'd0;
    end else begin
      if (out_fire_s && (stat_words_q != 32'hFFFF_FFFF)) begin
        stat_words_d = stat_words_q + 32'd1;
      end else begin
        stat_words_d = stat_words_q;
      end
      if (out_valid_q && !out_ready && (stat_stalls_q != 32'hFFFF_FFFF)) begin
        stat_stalls_d = stat_stalls_q + 32'd1;
      end else begin
        stat_stalls_d = stat_stalls_q;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q  <= 32'd0;
      stat_stalls_q <= 32'd0;
    end else begin
      stat_words_q  <= stat_words_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_words  = stat_words_q;
  assign stat_stalls = stat_stalls_q;
`else
  logic unused_start_accept_s;
  assign unused_start_accept_s = start_accept_s;
`endif

endmodule
